apb_rr_arbiter: RTL and testbench

Shares one apb_master instance between NUM_REQ independent requesters, such as a CPU load/store port, a DMA engine and a debug port.
- Round-robin arbitration; exactly one APB transaction in flight at a time.
- Issues a one-cycle start to the master and waits for its done.
- Captures read data and returns it to the granted requester as a registered one-cycle response.
- Sits between the requester ports and the master's start/write/addr/wdata/done/rdata interface.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_rr_arbiter_if.sv | 39 +++
 rtl/apb_rr_arbiter_rr_pick.sv | 32 +++
 rtl/apb_rr_arbiter.sv | 92 +++++++++
 tb/tb_apb_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB round-robin arbiter
package apb_pkg;

    localparam int APB_WIDTH   = 8;
    localparam int APB_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// rtl/apb_rr_arbiter_if.sv - requester and master-side signal bundle for apb_rr_arbiter
interface apb_rr_arbiter_if
    import apb_pkg::*;
#(
    parameter int NUM_REQ = APB_NUM_REQ,
    parameter int WIDTH   = APB_WIDTH,
    parameter int IDW     = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_write;
    logic [NUM_REQ*WIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_rdata;
    logic                     busy;
    logic [IDW-1:0]           grant_id;

    logic                     m_start;
    logic                     m_write;
    logic [WIDTH-1:0]         m_addr;
    logic [WIDTH-1:0]         m_wdata;
    logic                     m_done;
    logic [WIDTH-1:0]         m_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, m_done, m_rdata,
        output req_ready, rsp_valid, rsp_rdata, busy, grant_id,
               m_start, m_write, m_addr, m_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, m_done, m_rdata,
        input  req_ready, rsp_valid, rsp_rdata, busy, grant_id,
               m_start, m_write, m_addr, m_wdata
    );

endinterface

// File: rtl/apb_rr_arbiter_rr_pick.sv
// rtl/apb_rr_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any_valid
);

    // Scan ptr, ptr+1, ... wrapping; the first valid index wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && valid[idx]) begin
                any_valid  = 1'b1;
                grant_idx  = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin sharing of one apb_master among NUM_REQ requesters
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = APB_NUM_REQ,
    parameter int WIDTH   = APB_WIDTH,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    apb_rr_arbiter_if.slave  bus
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     grant_q;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               any_valid;
    logic               accept;
    logic               lat_write;
    logic [WIDTH-1:0]   lat_addr;
    logic [WIDTH-1:0]   lat_wdata;
    logic [WIDTH-1:0]   rdata_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .valid     (bus.req_valid),
        .ptr       (ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .any_valid (any_valid)
    );

    assign accept = (state == IDLE) && any_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.m_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured at accept so the requester is free to move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            grant_q   <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                lat_write <= bus.req_write[pick_idx];
                lat_addr  <= bus.req_addr[pick_idx*WIDTH +: WIDTH];
                lat_wdata <= bus.req_wdata[pick_idx*WIDTH +: WIDTH];
                grant_q   <= pick_idx;
                ptr       <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (state == WAIT && bus.m_done) begin
                rdata_q <= bus.m_rdata;
            end
        end
    end

    assign bus.req_ready = accept ? pick_onehot : '0;
    assign bus.rsp_valid = (state == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = grant_q;
    assign bus.m_start   = (state == ISSUE);
    assign bus.m_write   = lat_write;
    assign bus.m_addr    = lat_addr;
    assign bus.m_wdata   = lat_wdata;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb/tb_apb_rr_arbiter.sv - directed self-checking bench for apb_rr_arbiter
module tb_apb_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   ws;
    int   cnt;
    int   n_writes;
    logic slave_done;
    logic stray_done;
    logic [7:0] slave_rdata;
    logic [7:0] mem [256];
    bit   ok;

    apb_rr_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

    apb_rr_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.m_done  = slave_done | stray_done;
    assign bus.m_rdata = slave_rdata;

    // Stand-in for apb_master plus slave: done arrives 2 edges after start, plus ws.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 0;
            slave_done  <= 1'b0;
            slave_rdata <= 8'h00;
        end else begin
            slave_done <= 1'b0;
            if (bus.m_start) begin
                cnt <= ws + 1;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end else if (cnt == 1) begin
                cnt        <= 0;
                slave_done <= 1'b1;
                if (bus.m_write) begin
                    mem[bus.m_addr] <= bus.m_wdata;
                    slave_rdata     <= bus.m_wdata;
                    n_writes        <= n_writes + 1;
                end else begin
                    slave_rdata <= mem[bus.m_addr];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
        bus.req_valid[i]         = 1'b1;
        bus.req_write[i]         = w;
        bus.req_addr[i*8 +: 8]  = a;
        bus.req_wdata[i*8 +: 8] = d;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.req_ready != 0) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.rsp_valid != 0) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        order       = '{0, 1, 2, 3, 0};
        n_tests     = 0;
        n_fail      = 0;
        ws          = 0;
        n_writes    = 0;
        stray_done  = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) tick();

        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_m_start", bus.m_start, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        rst_n = 1'b1;
        tick();

        // Single write, zero-wait latency T..T+5
        set_req(0, 1'b1, 8'h10, 8'hA5);
        #1;
        chk("wr_ready_T", bus.req_ready, 4'b0001);
        tick();
        clr_req(0);
        #1;
        chk("wr_m_start_T1", bus.m_start, 1);
        chk("wr_m_addr_T1", bus.m_addr, 8'h10);
        chk("wr_m_wdata_T1", bus.m_wdata, 8'hA5);
        chk("wr_m_write_T1", bus.m_write, 1);
        chk("wr_ready_T1", bus.req_ready, 0);
        tick();
        chk("wr_m_start_T2", bus.m_start, 0);
        chk("wr_busy_T2", bus.busy, 1);
        tick();
        chk("wr_rsp_T3", bus.rsp_valid, 0);
        tick();
        chk("wr_rsp_T4", bus.rsp_valid, 4'b0001);
        chk("wr_mem", mem[8'h10], 8'hA5);
        tick();
        chk("wr_rsp_T5", bus.rsp_valid, 0);
        chk("wr_busy_T5", bus.busy, 0);

        // Read back via requester 2
        set_req(2, 1'b0, 8'h10, 8'h00);
        #1;
        chk("rd_ready", bus.req_ready, 4'b0100);
        tick();
        clr_req(2);
        #1;
        wait_rsp(ok);
        chk("rd_rsp_timeout", ok, 1);
        chk("rd_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("rd_rsp_rdata", bus.rsp_rdata, 8'hA5);
        chk("rd_grant_id", bus.grant_id, 2);

        // Contention from reset: order 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h20 + 8'(i), 8'h30 + 8'(i));
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_ready(ok);
            chk("ct_ready_timeout", ok, 1);
            chk($sformatf("ct_ready_%0d", k), bus.req_ready, 4'b0001 << order[k]);
            tick();
            if (k == 4) bus.req_valid = '0;
            chk($sformatf("ct_grant_%0d", k), bus.grant_id, order[k]);
            wait_rsp(ok);
            chk("ct_rsp_timeout", ok, 1);
            chk($sformatf("ct_rsp_%0d", k), bus.rsp_valid, 4'b0001 << order[k]);
            tick();
        end

        // Wait states: ws=5
        ws = 5;
        set_req(1, 1'b0, 8'h21, 8'h00);
        #1;
        chk("ws_ready", bus.req_ready, 4'b0010);
        tick();
        clr_req(1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ws_busy", bus.busy, 1);
            chk("ws_rsp", bus.rsp_valid, 0);
            chk("ws_m_addr", bus.m_addr, 8'h21);
            chk("ws_m_start", bus.m_start, 0);
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.m_done) begin
                ok = 1'b1;
                break;
            end
            chk("ws_rsp_before_done", bus.rsp_valid, 0);
            tick();
        end
        chk("ws_done_timeout", ok, 1);
        tick();
        chk("ws_rsp_after_done", bus.rsp_valid, 4'b0010);
        chk("ws_rdata", bus.rsp_rdata, 8'h31);
        ws = 0;
        tick();

        // Withdrawal by req1 while req3 is served, then stray done in IDLE
        set_req(3, 1'b0, 8'h10, 8'h00);
        #1;
        chk("wd_ready", bus.req_ready, 4'b1000);
        tick();
        clr_req(3);
        set_req(1, 1'b1, 8'h40, 8'hEE);
        tick();
        clr_req(1);
        #1;
        chk("wd_ready_busy", bus.req_ready, 0);
        wait_rsp(ok);
        chk("wd_rsp_timeout", ok, 1);
        chk("wd_rsp", bus.rsp_valid, 4'b1000);
        chk("wd_rdata", bus.rsp_rdata, 8'hA5);
        tick();
        chk("wd_idle_ready", bus.req_ready, 0);
        chk("wd_idle_busy", bus.busy, 0);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stray_rsp", bus.rsp_valid, 0);
            chk("stray_busy", bus.busy, 0);
            tick();
        end
        chk("stray_grant_id", bus.grant_id, 3);

        // Reset during WAIT
        ws = 5;
        set_req(0, 1'b1, 8'h50, 8'h77);
        #1;
        chk("rw_ready", bus.req_ready, 4'b0001);
        tick();
        clr_req(0);
        tick();
        tick();
        chk("rw_in_wait", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy", bus.busy, 0);
        chk("rw_m_addr", bus.m_addr, 0);
        chk("rw_m_wdata", bus.m_wdata, 0);
        chk("rw_m_write", bus.m_write, 0);
        chk("rw_grant_id", bus.grant_id, 0);
        chk("rw_rsp_rdata", bus.rsp_rdata, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rw_rsp", bus.rsp_valid, 0);
        end
        rst_n = 1'b1;
        ws = 0;
        tick();
        set_req(0, 1'b0, 8'h10, 8'h00);
        set_req(3, 1'b0, 8'h20, 8'h00);
        #1;
        chk("rw_ptr0_ready", bus.req_ready, 4'b0001);
        tick();
        clr_req(0);
        clr_req(3);
        #1;
        wait_rsp(ok);
        chk("rw_rsp_timeout", ok, 1);
        chk("rw_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("rw_rdata", bus.rsp_rdata, 8'hA5);
        chk("rw_grant_after", bus.grant_id, 0);
        chk("total_writes", n_writes, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
